// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states,
// and a two's-complement negate usable at any operand width.
package hilo_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  // Negation commutes with truncation, so callers widen to NEG_W, negate,
  // and cast back; NEG_W must cover the 2*WIDTH product.
  localparam int NEG_W = 128;

  function automatic logic [NEG_W-1:0] neg2c(input logic [NEG_W-1:0] x);
    return ~x + NEG_W'(1);
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Pipeline-side bundle of the HI/LO unit: launch controls in, status and
// architectural HI/LO out.
interface hilo_muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (output start, op, src_a, src_b, flush,
                  input  busy, done, hi_out, lo_out);
  modport slave  (input  start, op, src_a, src_b, flush,
                  output busy, done, hi_out, lo_out);
endinterface

// File: rtl/hilo_muldiv_iter.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide,
// one bit per step, over a shared 2*WIDTH accumulator.
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             mode_div_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   addend_q, addend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_div_q, mode_div_d;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? addend_q : '0)};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, addend_q};
    // Remainder stays below the divisor, so a successful subtract fits WIDTH bits.
    div_diff  = div_shift[WIDTH-1:0] - addend_q;
    acc_d      = acc_q;
    addend_d   = addend_q;
    mode_div_d = mode_div_q;
    cnt_d      = cnt_q;
    if (load_i) begin
      mode_div_d = mode_div_i;
      addend_d   = mode_div_i ? opb_i : opa_i;
      acc_d      = {{WIDTH{1'b0}}, (mode_div_i ? opa_i : opb_i)};
      cnt_d      = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (mode_div_q)
        acc_d = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                       : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      addend_q   <= '0;
      cnt_q      <= '0;
      mode_div_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      addend_q   <= addend_d;
      cnt_q      <= cnt_d;
      mode_div_q <= mode_div_d;
    end
  end

  assign last_o = step_i && (cnt_q == CNT_W'(WIDTH - 1));
  assign hi_o   = acc_q[2*WIDTH-1:WIDTH];
  assign lo_o   = acc_q[WIDTH-1:0];

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO architectural registers with control FSM and sign handling around an
// unsigned iterative multiply/divide engine.
module hilo_muldiv import hilo_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic           clk,
  input logic           reset,
  hilo_muldiv_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, a_raw_q, a_raw_d;
  logic             done_q, done_d;
  logic             is_div_q, is_div_d, neg_p_q, neg_p_d, neg_r_q, neg_r_d;
  logic             divz_q, divz_d;
  logic             is_signed, is_div, neg_a, neg_b, launch, mtx, last;
  logic [WIDTH-1:0] abs_a, abs_b, it_hi, it_lo, quo, rem;
  logic [2*WIDTH-1:0] prod;

  muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (launch),
    .step_i     (state_q == CALC),
    .mode_div_i (is_div),
    .opa_i      (abs_a),
    .opb_i      (abs_b),
    .last_o     (last),
    .hi_o       (it_hi),
    .lo_o       (it_lo)
  );

  always_comb begin
    is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    is_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    neg_a     = is_signed && bus.src_a[WIDTH-1];
    neg_b     = is_signed && bus.src_b[WIDTH-1];
    abs_a     = neg_a ? WIDTH'(neg2c(NEG_W'(bus.src_a))) : bus.src_a;
    abs_b     = neg_b ? WIDTH'(neg2c(NEG_W'(bus.src_b))) : bus.src_b;
    // flush outranks start, so a same-cycle start is dropped
    launch    = (state_q == IDLE) && bus.start && !bus.flush && (bus.op <= OP_DIVU);
    mtx       = (state_q == IDLE) && bus.start && !bus.flush &&
                ((bus.op == OP_MTHI) || (bus.op == OP_MTLO));

    prod = neg_p_q ? (2*WIDTH)'(neg2c(NEG_W'({it_hi, it_lo}))) : {it_hi, it_lo};
    quo  = neg_p_q ? WIDTH'(neg2c(NEG_W'(it_lo))) : it_lo;
    rem  = neg_r_q ? WIDTH'(neg2c(NEG_W'(it_hi))) : it_hi;

    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    a_raw_d  = a_raw_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    divz_d   = divz_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (launch) begin
          state_d  = CALC;
          a_raw_d  = bus.src_a;
          is_div_d = is_div;
          neg_p_d  = neg_a ^ neg_b;
          neg_r_d  = neg_a;
          divz_d   = (bus.src_b == '0);
        end
        if (mtx) begin
          if (bus.op == OP_MTHI) hi_d = bus.src_a;
          else                   lo_d = bus.src_a;
        end
      end
      CALC: begin
        if (bus.flush)  state_d = IDLE;
        else if (last)  state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        if (!bus.flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod;
          end else if (divz_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      a_raw_q  <= '0;
      done_q   <= 1'b0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      divz_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      a_raw_q  <= a_raw_d;
      done_q   <= done_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      divz_q   <= divz_d;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed-vector bench for hilo_muldiv at WIDTH=32.
module tb_hilo_muldiv;
  import hilo_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  hilo_muldiv_if #(.WIDTH(32)) bus();

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Launch an op, scramble operands after the launch edge, optionally pulse an
  // MTLO at busy-cycle inj, then check latency and the landed results.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int inj);
    int n, dn;
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    tick();
    bus.start = 1'b0; bus.src_a = 32'hA5A5_A5A5; bus.src_b = 32'h5A5A_5A5A;
    n = 0; dn = 0;
    while (bus.busy && n < 100) begin
      if (n == inj) begin
        bus.start = 1'b1; bus.op = OP_MTLO; bus.src_a = 32'h0000_DEAD;
      end else begin
        bus.start = 1'b0;
      end
      n++;
      if (bus.done) dn++;
      tick();
    end
    bus.start = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(n), 64'd33);
    chk({tag, "_done_early"}, 64'(dn), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_hi"}, 64'(bus.hi_out), 64'(eh));
    chk({tag, "_lo"}, 64'(bus.lo_out), 64'(el));
  endtask

  initial begin
    int dn;
    reset = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'd0;
    bus.src_a = '0; bus.src_b = '0;
    repeat (3) tick();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi", 64'(bus.hi_out), 64'd0);
    chk("rst_lo", 64'(bus.lo_out), 64'd0);
    reset = 1'b0;
    tick();

    // MTHI while idle
    bus.start = 1'b1; bus.op = OP_MTHI; bus.src_a = 32'h1234_5678;
    tick();
    bus.start = 1'b0;
    chk("mthi_hi", 64'(bus.hi_out), 64'h1234_5678);
    chk("mthi_lo", 64'(bus.lo_out), 64'd0);
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    tick();
    chk("mthi_nodone", 64'(bus.done), 64'd0);

    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, -1);
    tick();
    chk("mult_done_once", 64'(bus.done), 64'd0);

    // MULTU then DIV issued in the done cycle (back-to-back)
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, -1);
    run_op("divu_z", OP_DIVU, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, -1);
    run_op("div_z", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, -1);
    run_op("mult_nn", OP_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0, 32'h6, -1);
    run_op("divu_mtlo", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'hE, 5);
    tick();

    // flush mid-MULTU
    bus.start = 1'b1; bus.op = OP_MULTU; bus.src_a = 32'd3; bus.src_b = 32'd4;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) dn++;
      tick();
    end
    chk("flush_nodone", 64'(dn), 64'd0);
    chk("flush_hi", 64'(bus.hi_out), 64'd2);
    chk("flush_lo", 64'(bus.lo_out), 64'hE);

    // flush beats a same-cycle start, for both engine ops and MTHI
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = OP_MULT; bus.src_a = 32'd9; bus.src_b = 32'd9;
    tick();
    chk("flush_start_busy", 64'(bus.busy), 64'd0);
    bus.op = OP_MTHI; bus.src_a = 32'hFFFF_0000;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_mthi_hi", 64'(bus.hi_out), 64'd2);

    // reset mid-MULT
    bus.start = 1'b1; bus.op = OP_MULT; bus.src_a = 32'd11; bus.src_b = 32'd13;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_hi", 64'(bus.hi_out), 64'd0);
    chk("midrst_lo", 64'(bus.lo_out), 64'd0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) dn++;
      tick();
    end
    chk("midrst_nodone", 64'(dn), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Parametrised successor to the single HI register: owns the HI/LO architectural pair and an iterative multiply/divide engine.
- Executes MULT, MULTU, DIV, DIVU over WIDTH+1 cycles; MTHI/MTLO write directly.
- Sits beside the execute stage; the pipeline stalls on busy and reads hi_out/lo_out for MFHI/MFLO.

Parameters:
- WIDTH, 32: operand and HI/LO register width; must be ≥ 2.
- CNT_W, $clog2(WIDTH+1): width of the iteration counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch an operation this cycle; qualified by op.
- op  input  3  operation code: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; codes 6–7 are no-ops.
- src_a  input  WIDTH  multiplicand/dividend, or MTHI/MTLO data.
- src_b  input  WIDTH  multiplier/divisor.
- flush  input  1  abort any in-flight operation; HI/LO keep their values.
- busy  output  1  engine occupied; new start is ignored.
- done  output  1  one-cycle pulse when MULT/DIV results land in HI/LO.
- hi_out  output  WIDTH  current HI.
- lo_out  output  WIDTH  current LO.

Behaviour:
- Reset (any state, including mid-operation): hi_out=0, lo_out=0, busy=0, done=0, state=IDLE, counter=0.
- States: IDLE, CALC, FIX.
  - IDLE → CALC when start is high and op is 0–3.
  - CALC runs WIDTH cycles, then goes to FIX.
  - FIX → IDLE after 1 cycle.
- busy = (state != IDLE).
- Latency for op 0–3:
  - start sampled at edge E0.
  - busy is high from after E0 until E(WIDTH+1).
  - hi_out/lo_out update at E(WIDTH+1); done=1 for exactly the cycle after E(WIDTH+1), when the new values are already visible.
- MTHI/MTLO (op 4/5) with start while IDLE:
  - Writes src_a to HI or LO at the next edge; the other register is unchanged.
  - busy stays 0 and no done pulse is generated.
- start while busy is ignored, including MTHI/MTLO. The stall is the pipeline's responsibility.
- Operands are latched at E0. Later changes to src_a/src_b have no effect.
- Signed ops:
  - Take absolute values at latch and record the result signs.
  - FIX applies two's-complement correction.
  - Product sign = sign_a XOR sign_b.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
- MULT/MULTU: shift-add, one multiplier bit per CALC cycle. Full 2·WIDTH product: {HI,LO} = product.
- DIV/DIVU: restoring division, one quotient bit per CALC cycle. LO = quotient, HI = remainder.
- Divide by zero (signed or unsigned): LO = all ones, HI = src_a unchanged; same latency, done still pulses.
- Signed overflow (most-negative ÷ −1): LO = most-negative, HI = 0; no trap.
- flush:
  - In CALC/FIX: next state is IDLE, HI/LO are not written, no done pulse.
  - In IDLE: no effect.
  - flush and start in the same cycle: flush wins and the start is dropped.
- reset has priority over flush, which has priority over start.
- Back-to-back: a start in the done cycle is accepted, because state is already IDLE.

Decomposition:
- Shared package hilo_pkg holds:
  - op encodings OP_MULT..OP_MTLO;
  - the state enum {IDLE, CALC, FIX};
  - a function for WIDTH-generic two's-complement negate.
- One natural sub-module: muldiv_iter. It holds the shared shift/accumulate datapath, the counter, and a mode select (mul/div).
- The top level keeps the FSM control, sign handling, and the HI/LO registers.

Test Plan (WIDTH=32):
- MULT, a=0xFFFFFFFD (−3), b=5 → after 33 cycles: HI=0xFFFFFFFF, LO=0xFFFFFFF1, done pulses once, busy is high for exactly 33 cycles.
- MULTU, a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV, a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000 ÷ 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU, a=7, b=0 → LO=0xFFFFFFFF, HI=0x00000007, done pulses.
- MTHI 0x12345678 while IDLE → hi_out updates next cycle, LO unchanged, busy=0.
  - MTLO issued mid-DIV → ignored; the final LO is the quotient.
- Start MULT, assert flush at cycle 10 → busy drops next cycle, no done, HI/LO keep prior values.
  - Repeat with reset at cycle 10 → all outputs 0.
